w_wb_arbiter: RTL and testbench

Writeback-port arbiter between the W stage and the register file's single write port. It merges pipeline W-stage writes with results from a long-latency execution unit (MDU/coprocessor) through a one-entry hold buffer. Pipeline writes have priority. A starvation counter forces a pipeline freeze so that buffered results always drain. The outputs drive the register file's write port directly, and the block exposes the buffered entry to D-stage forwarding/hazard logic.

---
 rtl/w_wb_arbiter_pkg.sv | 13 +
 rtl/w_wb_arbiter_hold_entry.sv | 47 ++++
 rtl/w_wb_arbiter.sv | 107 ++++++++++
 tb/tb_w_wb_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/w_wb_arbiter_pkg.sv
// Shared constants and types for the writeback-port arbiter.
package w_wb_arbiter_pkg;

   localparam logic [4:0] REG_ZERO        = 5'd0;
   localparam int unsigned WB_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_BUF  = 2'd2
   } grant_e;

endpackage

// File: rtl/w_wb_arbiter_hold_entry.sv
// One-entry hold buffer for long-latency results plus the count of cycles
// the entry has been passed over by pipeline writes.
module wb_hold_entry #(
   parameter logic [3:0] LIMIT = 4'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [4:0]  ldAddr,
   input  logic [31:0] ldData,
   input  logic [31:0] ldPc,
   input  logic        drain,
   input  logic        kill,
   input  logic        pipeWon,
   output logic        bufValid,
   output logic [4:0]  bufAddr,
   output logic [31:0] bufData,
   output logic [31:0] bufPc,
   output logic [3:0]  waitCnt
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bufValid <= 1'b0;
         bufAddr  <= '0;
         bufData  <= '0;
         bufPc    <= '0;
         waitCnt  <= '0;
      end else begin
         // load only happens while empty, so it never races drain/kill
         if (load) begin
            bufValid <= 1'b1;
            bufAddr  <= ldAddr;
            bufData  <= ldData;
            bufPc    <= ldPc;
         end else if (drain || kill) begin
            bufValid <= 1'b0;
         end

         if (!bufValid || drain || kill)
            waitCnt <= '0;
         else if (pipeWon && (waitCnt != LIMIT))
            waitCnt <= waitCnt + 4'd1;
      end
   end

endmodule

// File: rtl/w_wb_arbiter.sv
// Register-file write-port arbiter: W-stage writes win over the buffered
// long-latency result until starvation forces a pipeline freeze.
module w_wb_arbiter
   import w_wb_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        w_we,
   input  logic [4:0]  w_addr,
   input  logic [31:0] w_data,
   input  logic [31:0] w_pc,
   input  logic        x_valid,
   output logic        x_ready,
   input  logic [4:0]  x_addr,
   input  logic [31:0] x_data,
   input  logic [31:0] x_pc,
   output logic        stall_req,
   output logic        pend_valid,
   output logic [4:0]  pend_addr,
   output logic [31:0] pend_data,
   output logic        regWriteEn,
   output logic [4:0]  regWriteAddr,
   output logic [31:0] regWriteData,
   output logic [31:0] PC
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic        bufValid;
   logic [4:0]  bufAddr;
   logic [31:0] bufData;
   logic [31:0] bufPc;
   logic [3:0]  waitCnt;
   logic        wLive;
   logic        xLoad;
   logic        drain;
   logic        kill;
   logic        pipeWon;
   grant_e      grant;

   assign wLive     = w_we && (w_addr != REG_ZERO);
   assign stall_req = bufValid && (waitCnt == LIMIT);
   assign x_ready   = !bufValid && reset;
   // $0 results complete the handshake but are never buffered
   assign xLoad     = x_valid && x_ready && (x_addr != REG_ZERO);

   // reset gates the pipeline path; buffer state is already clear then
   always_comb begin
      grant = GNT_NONE;
      if (stall_req)
         grant = GNT_BUF;
      else if (wLive && reset)
         grant = GNT_PIPE;
      else if (bufValid)
         grant = GNT_BUF;
   end

   assign drain   = (grant == GNT_BUF);
   assign pipeWon = (grant == GNT_PIPE);
   assign kill    = pipeWon && bufValid && (w_addr == bufAddr);

   always_comb begin
      regWriteEn   = 1'b0;
      regWriteAddr = '0;
      regWriteData = '0;
      PC           = '0;
      case (grant)
         GNT_PIPE: begin
            regWriteEn   = 1'b1;
            regWriteAddr = w_addr;
            regWriteData = w_data;
            PC           = w_pc;
         end
         GNT_BUF: begin
            regWriteEn   = 1'b1;
            regWriteAddr = bufAddr;
            regWriteData = bufData;
            PC           = bufPc;
         end
         default: ;
      endcase
   end

   wb_hold_entry #(.LIMIT(LIMIT)) u_hold (
      .clk      (clk),
      .reset    (reset),
      .load     (xLoad),
      .ldAddr   (x_addr),
      .ldData   (x_data),
      .ldPc     (x_pc),
      .drain    (drain),
      .kill     (kill),
      .pipeWon  (pipeWon),
      .bufValid (bufValid),
      .bufAddr  (bufAddr),
      .bufData  (bufData),
      .bufPc    (bufPc),
      .waitCnt  (waitCnt)
   );

   assign pend_valid = bufValid;
   assign pend_addr  = bufAddr;
   assign pend_data  = bufData;

endmodule

// File: tb/tb_w_wb_arbiter.sv
// Directed + randomized bench for w_wb_arbiter against a transaction-level
// model of the pending result and its age.
module tb_w_wb_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        w_we = 1'b0;
   logic [4:0]  w_addr = '0;
   logic [31:0] w_data = '0, w_pc = '0;
   logic        x_valid = 1'b0;
   logic [4:0]  x_addr = '0;
   logic [31:0] x_data = '0, x_pc = '0;
   logic        x_ready, stall_req, pend_valid;
   logic [4:0]  pend_addr, regWriteAddr;
   logic [31:0] pend_data, regWriteData, PC;
   logic        regWriteEn;

   w_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_pc(w_pc),
      .x_valid(x_valid), .x_ready(x_ready), .x_addr(x_addr), .x_data(x_data), .x_pc(x_pc),
      .stall_req(stall_req), .pend_valid(pend_valid), .pend_addr(pend_addr), .pend_data(pend_data),
      .regWriteEn(regWriteEn), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData), .PC(PC)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;

   // Model: at most one pending result, aged by cycles the pipeline took the port.
   bit          mValid;
   logic [4:0]  mAddr;
   logic [31:0] mData, mPc;
   int          mAge;

   logic [69:0] eWr;
   bit          eStall, eBufWrites, eLive, eAcc;
   logic [69:0] oWr;
   logic        oStall, oPend;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic modelClear();
      mValid = 0; mAddr = '0; mData = '0; mPc = '0; mAge = 0;
   endtask

   // Called at posedge+1 after inputs are driven; returns at next posedge+1.
   task automatic tick(input string tag);
      #2;
      eStall     = mValid && (mAge == LIMIT);
      eLive      = w_we && (w_addr != 5'd0);
      eBufWrites = eStall || (!eLive && mValid);
      if (eBufWrites)  eWr = {1'b1, mAddr, mData, mPc};
      else if (eLive)  eWr = {1'b1, w_addr, w_data, w_pc};
      else             eWr = '0;
      eAcc = x_valid && !mValid;
      oWr    = {regWriteEn, regWriteAddr, regWriteData, PC};
      oStall = stall_req;
      oPend  = pend_valid;
      chk({tag, ".wr"}, 96'(oWr), 96'(eWr));
      chk({tag, ".ctl"}, 96'({stall_req, x_ready, pend_valid}), 96'({eStall, !mValid, mValid}));
      if (mValid) chk({tag, ".pend"}, 96'({pend_addr, pend_data}), 96'({mAddr, mData}));
      @(posedge clk);
      if (eBufWrites) begin
         mValid = 0; mAge = 0;
      end else if (mValid && eLive) begin
         if (w_addr == mAddr) begin mValid = 0; mAge = 0; end
         else if (mAge < LIMIT) mAge++;
      end
      if (eAcc && x_addr != 5'd0) begin
         mValid = 1; mAddr = x_addr; mData = x_data; mPc = x_pc; mAge = 0;
      end
      #1;
   endtask

   task automatic idle();
      w_we = 0; w_addr = '0; x_valid = 0; x_addr = '0;
   endtask

   initial begin
      int   stallAt;
      bit   sawOld, holdW, xAccepted;
      logic [69:0] stallWr;

      // reset held with a live W write presented
      modelClear();
      reset = 0; w_we = 1; w_addr = 5'd5; w_data = 32'hCAFE; w_pc = 32'h100;
      x_valid = 1; x_addr = 5'd7; x_data = 32'h77;
      #3;
      chk("rst.we", 96'(regWriteEn), 96'(0));
      chk("rst.xready", 96'(x_ready), 96'(0));
      chk("rst.outs", 96'({regWriteEn, regWriteAddr, regWriteData, PC, stall_req, pend_valid}), 96'(0));
      repeat (2) @(posedge clk);
      #1; idle(); reset = 1;
      tick("rel");
      chk("rel.xready", 96'(oWr[69] == 0 && x_ready), 96'(1));

      // idle-slot drain
      x_valid = 1; x_addr = 5'd8; x_data = 32'h1234; x_pc = 32'h400;
      tick("idl.acc");
      idle();
      tick("idl.wr");
      chk("idl.write", 96'(oWr), 96'({1'b1, 5'd8, 32'h1234, 32'h400}));
      tick("idl.after");
      chk("idl.pend", 96'(oPend), 96'(0));

      // starvation: pipeline hogs the port until the freeze
      x_valid = 1; x_addr = 5'd9; x_data = 32'hAAAA; x_pc = 32'h500;
      tick("stv.acc");
      x_valid = 0; w_we = 1; w_addr = 5'd3; w_data = 32'h3333; w_pc = 32'h600;
      stallAt = 0; stallWr = '0;
      for (int k = 1; k <= 12 && stallAt == 0; k++) begin
         tick("stv");
         if (oStall) begin stallAt = k; stallWr = oWr; end
      end
      chk("stv.cycle", 96'(stallAt), 96'(LIMIT + 1));
      chk("stv.write", 96'(stallWr), 96'({1'b1, 5'd9, 32'hAAAA, 32'h500}));
      tick("stv.next");
      chk("stv.next", 96'({oStall, oWr}), 96'({1'b0, 1'b1, 5'd3, 32'h3333, 32'h600}));
      idle();

      // supersede: newer W write to the same register kills the entry
      x_valid = 1; x_addr = 5'd4; x_data = 32'h1; x_pc = 32'h700;
      tick("sup.acc");
      x_valid = 0; w_we = 1; w_addr = 5'd4; w_data = 32'h2; w_pc = 32'h704;
      tick("sup.w");
      chk("sup.write", 96'(oWr), 96'({1'b1, 5'd4, 32'h2, 32'h704}));
      idle();
      sawOld = 0;
      for (int k = 0; k < 5; k++) begin
         tick("sup.quiet");
         if (oWr[69] && oWr[63:32] == 32'h1) sawOld = 1;
         if (k == 0) chk("sup.pend", 96'(oPend), 96'(0));
      end
      chk("sup.noold", 96'(sawOld), 96'(0));

      // zero register on both paths
      x_valid = 1; x_addr = 5'd0; x_data = 32'hDEAD;
      tick("zr.x");
      x_valid = 0;
      tick("zr.xnext");
      chk("zr.xwr", 96'({oWr[69], oPend}), 96'(0));
      w_we = 1; w_addr = 5'd0; w_data = 32'hBEEF;
      tick("zr.w");
      chk("zr.wwe", 96'(oWr[69]), 96'(0));
      idle();

      // reset asserted mid-cycle with an entry pending
      x_valid = 1; x_addr = 5'd10; x_data = 32'h5A5A; x_pc = 32'h800;
      tick("rm.acc");
      x_valid = 0; w_we = 1; w_addr = 5'd6; w_data = 32'h66;
      #1 reset = 0;
      #1;
      chk("rm.outs", 96'({regWriteEn, regWriteAddr, regWriteData, PC, stall_req, pend_valid, x_ready}), 96'(0));
      @(posedge clk);
      #1; idle(); reset = 1; modelClear();
      tick("rm.rel");

      // randomized traffic; frozen W repeats its write, x holds until taken
      holdW = 0; xAccepted = 1;
      for (int n = 0; n < 400; n++) begin
         if (!holdW) begin
            w_we   = ($urandom_range(0, 9) < 7);
            w_addr = 5'($urandom_range(0, 7));
            w_data = $urandom;
            w_pc   = $urandom;
         end
         if (xAccepted || !x_valid) begin
            x_valid = ($urandom_range(0, 3) == 0);
            x_addr  = 5'($urandom_range(0, 7));
            x_data  = $urandom;
            x_pc    = $urandom;
         end
         tick("rnd");
         holdW     = oStall;
         xAccepted = eAcc;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
